// File: rtl/readout_ctrl_pkg.sv
// Shared types and width helpers for the parametrised exposure/readout controller.
package readout_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        EXPOSE = 2'd2,
        READ   = 2'd3
    } state_e;

    // Bits needed to index n distinct values (0..n-1), never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/exposure_time_ctrl.sv
// Saturating exposure-time register driven by the increase/decrease buttons.
module exposure_time_ctrl #(
    parameter int unsigned EXP_W     = 5,
    parameter int unsigned EXP_MIN   = 2,
    parameter int unsigned EXP_MAX   = 30,
    parameter int unsigned EXP_RESET = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [EXP_W-1:0] exp_o
);

    logic [EXP_W-1:0] exp_q, exp_d;

    always_comb begin
        exp_d = exp_q;
        if (inc_i && !dec_i) begin
            exp_d = (exp_q >= EXP_W'(EXP_MAX)) ? EXP_W'(EXP_MAX) : exp_q + EXP_W'(1);
        end else if (dec_i && !inc_i) begin
            exp_d = (exp_q <= EXP_W'(EXP_MIN)) ? EXP_W'(EXP_MIN) : exp_q - EXP_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) exp_q <= EXP_W'(EXP_RESET);
        else       exp_q <= exp_d;
    end

    assign exp_o = exp_q;

endmodule

// File: rtl/readout_ctrl_param.sv
// Erase -> Expose -> per-row readout sequencer with N_ROWS rows and optional continuous capture.
module readout_ctrl_param
    import readout_ctrl_pkg::*;
#(
    parameter int unsigned EXP_W     = 5,
    parameter int unsigned EXP_MIN   = 2,
    parameter int unsigned EXP_MAX   = 30,
    parameter int unsigned EXP_RESET = 10,
    parameter int unsigned N_ROWS    = 2,
    parameter int unsigned ROW_CYC   = 4,
    parameter int unsigned ERASE_CYC = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Init,
    input  logic              Exp_increase,
    input  logic              Exp_decrease,
    input  logic              Continuous,
    output logic              Erase,
    output logic              Expose,
    output logic [N_ROWS-1:0] NRE,
    output logic              ADC,
    output logic              Busy,
    output logic              Frame_done,
    output logic [EXP_W-1:0]  Exp_time
);

    localparam int unsigned PH_W = cnt_width(max3(EXP_MAX, ROW_CYC, ERASE_CYC) + 1);
    localparam int unsigned RW   = cnt_width(N_ROWS);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [RW-1:0]     row_q, row_d;
    logic [EXP_W-1:0]  frame_exp_q, frame_exp_d;
    logic              erase_d, expose_d, adc_d, busy_d, done_d;
    logic [N_ROWS-1:0] nre_d;

    exposure_time_ctrl #(
        .EXP_W    (EXP_W),
        .EXP_MIN  (EXP_MIN),
        .EXP_MAX  (EXP_MAX),
        .EXP_RESET(EXP_RESET)
    ) u_exp (
        .clk_i(Clk),
        .rst_i(Reset),
        .inc_i(Exp_increase),
        .dec_i(Exp_decrease),
        .exp_o(Exp_time)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + PH_W'(1);
        row_d       = row_q;
        frame_exp_d = frame_exp_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (Init) state_d = ERASE;
            end
            ERASE: begin
                if (phase_q == PH_W'(ERASE_CYC - 1)) begin
                    state_d = EXPOSE;
                    phase_d = '0;
                end
            end
            EXPOSE: begin
                if (phase_q == PH_W'(frame_exp_q - EXP_W'(1))) begin
                    state_d = READ;
                    phase_d = '0;
                    row_d   = '0;
                end
            end
            READ: begin
                if (phase_q == PH_W'(ROW_CYC - 1)) begin
                    phase_d = '0;
                    if (row_q == RW'(N_ROWS - 1)) begin
                        done_d  = 1'b1;
                        state_d = Continuous ? ERASE : IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Latch the exposure for the whole frame so button presses only affect the next one.
        if (state_d == ERASE && state_q != ERASE) frame_exp_d = Exp_time;
    end

    // Outputs are decoded from the next state so they can be registered without extra latency.
    always_comb begin
        erase_d  = (state_d == ERASE);
        expose_d = (state_d == EXPOSE);
        busy_d   = (state_d != IDLE);
        adc_d    = (state_d == READ) && (phase_d != '0) && (phase_d != PH_W'(ROW_CYC - 1));
        nre_d    = '1;
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            if (state_d == READ && row_d == RW'(r)) nre_d[r] = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            row_q      <= '0;
            Erase      <= 1'b0;
            Expose     <= 1'b0;
            NRE        <= '1;
            ADC        <= 1'b0;
            Busy       <= 1'b0;
            Frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            row_q      <= row_d;
            Erase      <= erase_d;
            Expose     <= expose_d;
            NRE        <= nre_d;
            ADC        <= adc_d;
            Busy       <= busy_d;
            Frame_done <= done_d;
        end
    end

    always_ff @(posedge Clk) begin
        frame_exp_q <= frame_exp_d;
    end

endmodule

// File: tb/tb_readout_ctrl_param.sv
// Bench for readout_ctrl_param: a default instance (A) and a 4-row/5-cycle/2-erase instance (B).
module tb_readout_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b1, a_init = 1'b0, a_inc = 1'b0, a_dec = 1'b0, a_cont = 1'b0;
    logic       a_erase, a_expose, a_adc, a_busy, a_done;
    logic [1:0] a_nre;
    logic [4:0] a_expt;

    logic       b_rst = 1'b1, b_init = 1'b0, b_inc = 1'b0, b_dec = 1'b0, b_cont = 1'b0;
    logic       b_erase, b_expose, b_adc, b_busy, b_done;
    logic [3:0] b_nre;
    logic [4:0] b_expt;

    readout_ctrl_param u_a (
        .Clk(clk), .Reset(a_rst), .Init(a_init), .Exp_increase(a_inc), .Exp_decrease(a_dec),
        .Continuous(a_cont), .Erase(a_erase), .Expose(a_expose), .NRE(a_nre), .ADC(a_adc),
        .Busy(a_busy), .Frame_done(a_done), .Exp_time(a_expt)
    );

    readout_ctrl_param #(.N_ROWS(4), .ROW_CYC(5), .ERASE_CYC(2)) u_b (
        .Clk(clk), .Reset(b_rst), .Init(b_init), .Exp_increase(b_inc), .Exp_decrease(b_dec),
        .Continuous(b_cont), .Erase(b_erase), .Expose(b_expose), .NRE(b_nre), .ADC(b_adc),
        .Busy(b_busy), .Frame_done(b_done), .Exp_time(b_expt)
    );

    // Reference model: a frame is a timeline of cycles t = 1..len counted from its start edge.
    typedef struct {
        bit active;
        int t;
        int fexp;
        int expv;
        bit done;
    } mdl_t;

    typedef struct {
        logic        erase;
        logic        expose;
        logic        adc;
        logic        busy;
        logic        done;
        logic [31:0] nre;
        logic [31:0] expt;
    } exp_t;

    mdl_t ma = '{0, 0, 0, 10, 0};
    mdl_t mb = '{0, 0, 0, 10, 0};

    int checks = 0;
    int failures = 0;
    int a_expose_cnt = 0, a_done_cnt = 0, b_done_cnt = 0, b_idle_cnt = 0;

    function automatic mdl_t mstep(input mdl_t m, input bit rst, input bit init, input bit inc,
                                   input bit dec, input bit cont, input int ec, input int nr,
                                   input int rc);
        mdl_t n;
        n = m;
        if (rst) begin
            n.active = 0; n.t = 0; n.done = 0; n.expv = 10;
            return n;
        end
        n.done = 0;
        if (m.active) begin
            if (m.t == ec + m.fexp + nr * rc) begin
                n.done = 1;
                if (cont) begin n.t = 1; n.fexp = m.expv; end
                else n.active = 0;
            end else begin
                n.t = m.t + 1;
            end
        end else if (init) begin
            n.active = 1; n.t = 1; n.fexp = m.expv;
        end
        if (inc && !dec)      n.expv = (m.expv + 1 > 30) ? 30 : m.expv + 1;
        else if (dec && !inc) n.expv = (m.expv - 1 < 2) ? 2 : m.expv - 1;
        return n;
    endfunction

    function automatic exp_t mexp(input mdl_t m, input int ec, input int nr, input int rc);
        exp_t e;
        bit   rd;
        int   idx;
        e.erase  = m.active && (m.t <= ec);
        e.expose = m.active && (m.t > ec) && (m.t <= ec + m.fexp);
        rd       = m.active && (m.t > ec + m.fexp);
        e.nre    = (1 << nr) - 1;
        e.adc    = 1'b0;
        if (rd) begin
            idx = m.t - ec - m.fexp - 1;
            e.nre[idx / rc] = 1'b0;
            e.adc = ((idx % rc) >= 1) && ((idx % rc) <= rc - 2);
        end
        e.busy = m.active;
        e.done = m.done;
        e.expt = m.expv;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    task automatic tick();
        exp_t ea, eb;
        @(posedge clk);
        #1;
        ma = mstep(ma, a_rst, a_init, a_inc, a_dec, a_cont, 1, 2, 4);
        mb = mstep(mb, b_rst, b_init, b_inc, b_dec, b_cont, 2, 4, 5);
        ea = mexp(ma, 1, 2, 4);
        eb = mexp(mb, 2, 4, 5);
        cmp("a_erase", a_erase, ea.erase);    cmp("a_expose", a_expose, ea.expose);
        cmp("a_nre", a_nre, ea.nre);          cmp("a_adc", a_adc, ea.adc);
        cmp("a_busy", a_busy, ea.busy);       cmp("a_done", a_done, ea.done);
        cmp("a_exp_time", a_expt, ea.expt);
        cmp("b_erase", b_erase, eb.erase);    cmp("b_expose", b_expose, eb.expose);
        cmp("b_nre", b_nre, eb.nre);          cmp("b_adc", b_adc, eb.adc);
        cmp("b_busy", b_busy, eb.busy);       cmp("b_done", b_done, eb.done);
        cmp("b_exp_time", b_expt, eb.expt);
        if (a_expose) a_expose_cnt++;
        if (a_done)   a_done_cnt++;
        if (b_done)   b_done_cnt++;
        if (!b_busy)  b_idle_cnt++;
    endtask

    initial begin
        int done_at;
        int b_restart_ok;
        bit reached;

        // Reset for two cycles.
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;
        cmp("rst_exp_time", a_expt, 10);  cmp("rst_nre", a_nre, 2'b11);
        cmp("rst_erase", a_erase, 0);     cmp("rst_expose", a_expose, 0);
        cmp("rst_adc", a_adc, 0);         cmp("rst_busy", a_busy, 0);
        cmp("rst_done", a_done, 0);       cmp("rst_b_nre", b_nre, 4'hF);
        tick();

        // Single frame with default settings.
        a_init = 1'b1; tick(); a_init = 1'b0;
        cmp("sf_erase_first", a_erase, 1);
        a_expose_cnt = 0; done_at = 0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 11) cmp("sf_row0_nre", a_nre, 2'b10);
            if (i == 16) cmp("sf_row1_nre", a_nre, 2'b01);
            if (a_done && done_at == 0) done_at = i;
        end
        cmp("sf_expose_len", a_expose_cnt, 10);
        cmp("sf_done_cycle", done_at, 19);
        cmp("sf_busy_after", a_busy, 0);

        // Saturation of the exposure register.
        a_inc = 1'b1; repeat (25) tick(); a_inc = 1'b0;
        cmp("sat_hi", a_expt, 30);
        a_dec = 1'b1; repeat (40) tick(); a_dec = 1'b0;
        cmp("sat_lo", a_expt, 2);
        a_inc = 1'b1; a_dec = 1'b1; repeat (3) tick(); a_inc = 1'b0; a_dec = 1'b0;
        cmp("inc_dec_hold", a_expt, 2);
        a_inc = 1'b1; repeat (8) tick(); a_inc = 1'b0;
        cmp("set_ten", a_expt, 10);

        // Mid-frame increase must not alter the running frame.
        a_init = 1'b1; tick(); a_init = 1'b0;
        a_expose_cnt = 0;
        tick();
        a_inc = 1'b1; tick(); a_inc = 1'b0;
        repeat (20) tick();
        cmp("mid_expose_len", a_expose_cnt, 10);
        cmp("mid_exp_time", a_expt, 11);
        a_init = 1'b1; tick(); a_init = 1'b0;
        a_expose_cnt = 0;
        repeat (24) tick();
        cmp("next_expose_len", a_expose_cnt, 11);

        // Reset while reading row 1.
        a_init = 1'b1; tick(); a_init = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (ma.active && ma.t == 1 + ma.fexp + 4 + 2) reached = 1'b1;
        end
        cmp("rr_reached", reached, 1);
        cmp("rr_nre_row1", a_nre, 2'b01);
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        cmp("rr_nre", a_nre, 2'b11);  cmp("rr_adc", a_adc, 0);
        cmp("rr_busy", a_busy, 0);    cmp("rr_done", a_done, 0);
        a_done_cnt = 0;
        repeat (6) tick();
        cmp("rr_no_done", a_done_cnt, 0);

        // Continuous capture on B with an ignored second Init during EXPOSE.
        b_cont = 1'b1; b_init = 1'b1; tick(); b_init = 1'b0;
        b_done_cnt = 0; b_idle_cnt = 0; b_restart_ok = 0;
        for (int i = 1; i <= 79; i++) begin
            b_init = (i == 40);
            tick();
            if (i == 32 && b_done && b_erase) b_restart_ok = 1;
        end
        b_init = 1'b0;
        cmp("cont_done_count", b_done_cnt, 2);
        cmp("cont_no_idle", b_idle_cnt, 0);
        cmp("cont_restart", b_restart_ok, 1);
        b_cont = 1'b0; b_done_cnt = 0;
        repeat (25) tick();
        cmp("cont_stop_done", b_done_cnt, 1);
        cmp("cont_stop_idle", b_busy, 0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            a_rst  = ($urandom_range(0, 96) == 0);
            b_rst  = ($urandom_range(0, 96) == 0);
            a_init = ($urandom_range(0, 7) == 0);
            b_init = ($urandom_range(0, 7) == 0);
            a_inc  = ($urandom_range(0, 3) == 0);
            a_dec  = ($urandom_range(0, 3) == 0);
            b_inc  = ($urandom_range(0, 3) == 0);
            b_dec  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) a_cont = ~a_cont;
            if ($urandom_range(0, 15) == 0) b_cont = ~b_cont;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/readout_ctrl_param.md
Name: readout_ctrl_param

Overview:
Parametrised exposure/readout controller for the pixel array. It is the next generation of the fixed 2-row, 5-bit camera controller.
- Holds an adjustable exposure time and sequences Erase -> Expose -> per-row readout (active-low NRE strobe plus ADC pulse).
- Supports N_ROWS rows, a configurable row slot length, and single-shot or continuous capture mode.
- Sits between the user buttons/host and the pixel array plus ADC.

Parameters:
EXP_W, 5, width of exposure-time register (cycles)
EXP_MIN, 2, lower saturation bound of exposure time
EXP_MAX, 30, upper saturation bound, must be < 2**EXP_W
EXP_RESET, 10, exposure time after reset
N_ROWS, 2, number of readout rows (>=1)
ROW_CYC, 4, cycles per row readout slot (>=3)
ERASE_CYC, 1, cycles Erase is held high (>=1)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Init  input  1  start a frame (sampled only in IDLE)
Exp_increase  input  1  exposure +1 request
Exp_decrease  input  1  exposure -1 request
Continuous  input  1  1 = auto-restart after readout
Erase  output  1  pixel erase
Expose  output  1  pixel expose
NRE  output  N_ROWS  active-low row read enables; bit r = row r
ADC  output  1  ADC conversion strobe
Busy  output  1  high whenever state != IDLE
Frame_done  output  1  one-cycle pulse at end of readout
Exp_time  output  EXP_W  current exposure setting

Behaviour:
- One clock Clk; reset is synchronous and active-high on Reset. All outputs are registered.
- Reset values: Erase=0, Expose=0, NRE=all 1, ADC=0, Busy=0, Frame_done=0, Exp_time=EXP_RESET, state=IDLE.
- Reset asserted mid-frame: outputs take their reset values on that edge. Any frame in progress is abandoned, with no Frame_done.
- Exposure register:
  - Updated every cycle in any state.
  - inc&!dec: +1, saturating at EXP_MAX.
  - dec&!inc: -1, saturating at EXP_MIN.
  - Both or neither: hold.
  - The value is copied to an internal frame_exp on each entry to ERASE; a frame never sees mid-frame changes.
- FSM states: IDLE, ERASE, EXPOSE, READ.
  - IDLE: Init=1 -> ERASE. Init in any other state is ignored.
  - ERASE: Erase=1 for ERASE_CYC cycles -> EXPOSE.
  - EXPOSE: Expose=1 for exactly frame_exp cycles -> READ with row=0, slot=0.
  - READ, row r:
    - NRE[r]=0 for all ROW_CYC cycles of its slot; all other NRE bits are 1.
    - ADC=1 on slot cycles 1..ROW_CYC-2; ADC=0 on cycles 0 and ROW_CYC-1.
    - Rows proceed 0..N_ROWS-1 back-to-back.
  - After the last slot: Frame_done=1 for one cycle. Simultaneously the state goes to ERASE if Continuous=1 (sampled in the last READ cycle), otherwise to IDLE.
- Latency and length:
  - Init sampled at edge k -> Erase high from cycle k+1.
  - Frame length = ERASE_CYC + frame_exp + N_ROWS*ROW_CYC cycles.
  - Busy is high for the full frame.
- Counters:
  - Phase counter is sized ceil(log2(max(EXP_MAX, ROW_CYC, ERASE_CYC)+1)).
  - Row counter is sized ceil(log2(N_ROWS)), minimum 1 bit.
  - No wrap-around is permitted. Counters reset to 0 on every state entry.
- Outputs are mutually exclusive: Erase, Expose, and any NRE low never overlap.

Decomposition:
- Package readout_ctrl_pkg: state enum type (IDLE, ERASE, EXPOSE, READ) and a clog2-based width helper constant function.
- Sub-module exposure_time_ctrl (parameters EXP_W/EXP_MIN/EXP_MAX/EXP_RESET): the saturating exposure register.
- FSM and counters stay in the top module.

Test Plan:
- Reset, defaults: Reset for 2 cycles -> Exp_time=10, NRE=2'b11, all other outputs 0, Busy=0.
- Single frame, defaults: Init pulse -> Erase for 1 cycle, Expose for 10 cycles, then NRE=2'b10 for 4 cycles with ADC high on slot cycles 1-2, then NRE=2'b01 likewise. Frame_done on cycle 19 after Init, Busy low afterwards.
- Saturation:
  - 25 increase pulses from 10 -> Exp_time=30.
  - 40 decrease pulses -> Exp_time=2.
  - inc and dec together -> no change.
- Mid-frame change: set Exp_time=10, start a frame, press increase during EXPOSE -> Expose still 10 cycles. Exp_time reads 11, and the next frame exposes for 11.
- Continuous with N_ROWS=4, ROW_CYC=5: Continuous=1, one Init -> back-to-back frames with no IDLE cycle. Drop Continuous -> IDLE after the current frame. A second Init during EXPOSE is ignored.
- Reset during READ row 1 -> next cycle all NRE=1, ADC=0, Busy=0, no Frame_done pulse.
